mem_ctrl: RTL and testbench

Memory controller between the core's fetch/load-store side and the byte-wide main RAM. It answers 64-bit block requests from the instruction cache and 1/2/4-byte load/store requests from the load-store buffer. It serialises each request into per-byte RAM accesses and returns one `valid` pulse per request. It is the responder for the icache miss handshake (`mem_en`/`addr_to_mem` → `mem_valid`/`ins_blk`).

---
 rtl/mem_ctrl_pkg.sv | 27 ++
 rtl/mem_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serialising memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IC_READ  = 2'd1,
        LS_READ  = 2'd2,
        LS_WRITE = 2'd3
    } state_t;

    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] WORD = 2'b10;

    localparam logic [3:0] IC_BYTES = 4'd8;
    localparam logic [1:0] IO_SEL   = 2'b11;

    // Unknown width code 2'b11 is treated as a word access.
    function automatic logic [3:0] ls_bytes(input logic [1:0] width);
        case (width)
            BYTE:    return 4'd1;
            HALF:    return 4'd2;
            default: return 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: serialises icache block reads and load/store requests
// into per-byte accesses on the byte-wide main RAM.
module mem_ctrl #(
    parameter logic [1:0] IO_SEL = mem_ctrl_pkg::IO_SEL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        ic_en,
    input  logic [31:0] ic_addr,
    output logic        ic_valid,
    output logic [63:0] ic_blk,
    input  logic        ls_en,
    input  logic        ls_wr,
    input  logic [31:0] ls_addr,
    input  logic [1:0]  ls_width,
    input  logic [31:0] ls_wdata,
    output logic        ls_valid,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    import mem_ctrl_pkg::*;

    state_t      state_q, state_d;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [3:0]  k_q;
    logic [3:0]  n_q;
    logic        restart_q;
    logic        mem_wr_q;

    logic        ls_blocked;
    logic        ls_take;
    logic        can_accept;
    logic        acc_ls;
    logic        acc_ic;
    logic        rd_done;
    logic        wr_done;
    logic [31:0] next_a;
    logic [2:0]  lane;
    logic [1:0]  wsel;

    // A stalled write must never reach the RAM, even for the cycle rdy drops.
    assign mem_wr = mem_wr_q & rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ls_blocked = ls_wr && io_buffer_full && (ls_addr[17:16] == IO_SEL);
        ls_take    = ls_en && !ls_blocked;
        can_accept = (state_q == IDLE) && !ic_valid && !ls_valid;
        acc_ls     = can_accept && ls_take;
        acc_ic     = can_accept && !ls_take && ic_en;
        rd_done    = !restart_q && (k_q == n_q);
        wr_done    = (k_q == n_q - 4'd1);
        next_a     = base_q + {28'd0, k_q} + 32'd1;
        lane       = 3'(k_q - 4'd1);
        wsel       = 2'(k_q + 4'd1);
        state_d    = state_q;
        case (state_q)
            IDLE: begin
                if (acc_ls) begin
                    state_d = ls_wr ? LS_WRITE : LS_READ;
                end else if (acc_ic) begin
                    state_d = IC_READ;
                end
            end
            IC_READ, LS_READ: begin
                if (rd_done) begin
                    state_d = IDLE;
                end
            end
            LS_WRITE: begin
                if (wr_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // k_q is the byte index currently on mem_a; read data lags it by two edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= '0;
            wdata_q   <= '0;
            k_q       <= '0;
            n_q       <= '0;
            restart_q <= 1'b0;
            mem_wr_q  <= 1'b0;
            mem_a     <= '0;
            mem_dout  <= '0;
            ic_valid  <= 1'b0;
            ls_valid  <= 1'b0;
            ic_blk    <= '0;
            ls_rdata  <= '0;
        end else if (!rdy) begin
            // RAM keeps answering while we are frozen, so reads refetch.
            if (state_q == IC_READ || state_q == LS_READ) begin
                restart_q <= 1'b1;
            end
        end else begin
            ic_valid  <= 1'b0;
            ls_valid  <= 1'b0;
            restart_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    k_q <= '0;
                    if (acc_ls) begin
                        base_q   <= ls_addr;
                        wdata_q  <= ls_wdata;
                        n_q      <= ls_bytes(ls_width);
                        mem_a    <= ls_addr;
                        mem_dout <= ls_wr ? ls_wdata[7:0] : 8'd0;
                        mem_wr_q <= ls_wr;
                    end else if (acc_ic) begin
                        base_q   <= ic_addr;
                        n_q      <= IC_BYTES;
                        mem_a    <= ic_addr;
                        mem_dout <= '0;
                        mem_wr_q <= 1'b0;
                    end else begin
                        mem_a    <= '0;
                        mem_dout <= '0;
                        mem_wr_q <= 1'b0;
                    end
                end
                IC_READ, LS_READ: begin
                    if (restart_q) begin
                        k_q   <= '0;
                        mem_a <= base_q;
                    end else begin
                        if (k_q != 4'd0) begin
                            if (state_q == IC_READ) begin
                                ic_blk[{lane, 3'b000} +: 8] <= mem_din;
                            end else if (k_q == 4'd1) begin
                                ls_rdata <= {24'd0, mem_din};
                            end else begin
                                ls_rdata[{lane[1:0], 3'b000} +: 8] <= mem_din;
                            end
                        end
                        if (k_q == n_q) begin
                            if (state_q == IC_READ) begin
                                ic_valid <= 1'b1;
                            end else begin
                                ls_valid <= 1'b1;
                            end
                        end else begin
                            k_q <= k_q + 4'd1;
                            if (k_q + 4'd1 < n_q) begin
                                mem_a <= next_a;
                            end
                        end
                    end
                end
                LS_WRITE: begin
                    if (wr_done) begin
                        mem_wr_q <= 1'b0;
                        ls_valid <= 1'b1;
                    end else begin
                        k_q      <= k_q + 4'd1;
                        mem_a    <= next_a;
                        mem_dout <= wdata_q[{wsel, 3'b000} +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, write monitor and a
// byte-array reference memory that predicts every load, fetch and store.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        ic_en = 1'b0;
    logic [31:0] ic_addr = '0;
    logic        ic_valid;
    logic [63:0] ic_blk;
    logic        ls_en = 1'b0;
    logic        ls_wr = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [1:0]  ls_width = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_valid;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    int bad_wr = 0;
    logic [39:0] wq[$];

    always #5 clk = ~clk;

    mem_ctrl #(.IO_SEL(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ic_en(ic_en), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_blk(ic_blk),
        .ls_en(ls_en), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_width(ls_width),
        .ls_wdata(ls_wdata), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    function automatic logic [7:0] init_byte(input int a);
        if (a >= 'h10 && a < 'h18) return 8'(a - 'h10);
        return 8'((a * 151) ^ (a >> 3) ^ 'h5C);
    endfunction

    // Physical RAM (4 KiB, address aliased); registered read port.
    logic [7:0] ram [0:4095];
    bit         wflag [0:4095];
    always @(posedge clk) begin
        if (mem_wr) begin
            ram[mem_a[11:0]]   <= mem_dout;
            wflag[mem_a[11:0]] <= 1'b1;
        end
        mem_din <= wflag[mem_a[11:0]] ? ram[mem_a[11:0]] : init_byte(int'(mem_a[11:0]));
    end

    initial forever begin
        @(negedge clk);
        #2;
        if (mem_wr === 1'b1) begin
            wq.push_back({mem_a, mem_dout});
            if (rdy !== 1'b1) bad_wr++;
        end
    end

    // Reference model: plain byte array updated only by completed stores.
    logic [7:0] ref_mem [0:4095];

    function automatic int model_bytes(input logic [1:0] w);
        return (w == 2'b00) ? 1 : ((w == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input int nb);
        logic [31:0] r = '0;
        for (int k = 0; k < nb; k++) r[8*k +: 8] = ref_mem[12'(a + 32'(k))];
        return r;
    endfunction

    function automatic logic [63:0] model_block(input logic [31:0] a);
        logic [63:0] r = '0;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_mem[12'(a + 32'(k))];
        return r;
    endfunction

    task automatic model_store(input logic [31:0] a, input int nb, input logic [31:0] d);
        for (int k = 0; k < nb; k++) ref_mem[12'(a + 32'(k))] = d[8*k +: 8];
    endtask

    task automatic run_ls(input bit wr, input logic [31:0] addr, input logic [1:0] width,
                          input logic [31:0] wdata, input int stall_at,
                          output logic [31:0] rdata, output int lat, output int pulses);
        int cyc;
        @(negedge clk);
        ls_en = 1'b1; ls_wr = wr; ls_addr = addr; ls_width = width; ls_wdata = wdata;
        lat = -1; cyc = 0; pulses = 0;
        while (cyc < 60 && lat < 0) begin
            @(negedge clk);
            cyc++;
            if (ls_valid === 1'b1) begin
                lat = cyc; pulses++; ls_en = 1'b0;
            end
            if (cyc == stall_at) rdy = 1'b0;
            if (cyc == stall_at + 2) rdy = 1'b1;
        end
        rdy = 1'b1; ls_en = 1'b0; rdata = ls_rdata;
        repeat (3) begin
            @(negedge clk);
            if (ls_valid === 1'b1) pulses++;
        end
    endtask

    task automatic run_ic(input logic [31:0] addr, input int stall_at,
                          output logic [63:0] blk, output int lat, output int pulses);
        int cyc;
        @(negedge clk);
        ic_en = 1'b1; ic_addr = addr;
        lat = -1; cyc = 0; pulses = 0;
        while (cyc < 60 && lat < 0) begin
            @(negedge clk);
            cyc++;
            if (ic_valid === 1'b1) begin
                lat = cyc; pulses++; ic_en = 1'b0;
            end
            if (cyc == stall_at) rdy = 1'b0;
            if (cyc == stall_at + 2) rdy = 1'b1;
        end
        rdy = 1'b1; ic_en = 1'b0; blk = ic_blk;
        repeat (3) begin
            @(negedge clk);
            if (ic_valid === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        n_checks++; if (ic_valid !== 1'b0) $display("FAIL rst_ic_valid got %b want 0", ic_valid); else n_pass++;
        n_checks++; if (ls_valid !== 1'b0) $display("FAIL rst_ls_valid got %b want 0", ls_valid); else n_pass++;
        n_checks++; if (mem_wr !== 1'b0) $display("FAIL rst_mem_wr got %b want 0", mem_wr); else n_pass++;
        n_checks++; if (mem_a !== 32'd0) $display("FAIL rst_mem_a got %h want 0", mem_a); else n_pass++;
        n_checks++; if (mem_dout !== 8'd0) $display("FAIL rst_mem_dout got %h want 0", mem_dout); else n_pass++;
        n_checks++; if (ic_blk !== 64'd0) $display("FAIL rst_ic_blk got %h want 0", ic_blk); else n_pass++;
        n_checks++; if (ls_rdata !== 32'd0) $display("FAIL rst_ls_rdata got %h want 0", ls_rdata); else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (mem_a !== 32'd0) $display("FAIL idle_mem_a got %h want 0", mem_a); else n_pass++;
    endtask

    task automatic test_icache();
        logic [63:0] blk;
        logic [31:0] a;
        int lat, pulses;
        run_ic(32'h10, 0, blk, lat, pulses);
        n_checks++; if (blk !== 64'h0706050403020100) $display("FAIL ic_blk_0x10 got %h want 0706050403020100", blk); else n_pass++;
        n_checks++; if (lat !== 10) $display("FAIL ic_latency got %0d want 10", lat); else n_pass++;
        n_checks++; if (pulses !== 1) $display("FAIL ic_pulses got %0d want 1", pulses); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            a = {20'd0, 9'($urandom_range(0, 511)), 3'b000};
            run_ic(a, 0, blk, lat, pulses);
            n_checks++; if (blk !== model_block(a)) $display("FAIL ic_rand_blk @%h got %h want %h", a, blk, model_block(a)); else n_pass++;
            n_checks++; if (lat !== 10) $display("FAIL ic_rand_latency got %0d want 10", lat); else n_pass++;
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        int lat, pulses, start;
        start = wq.size();
        run_ls(1'b1, 32'h100, 2'b10, 32'hDEADBEEF, 0, rd, lat, pulses);
        model_store(32'h100, 4, 32'hDEADBEEF);
        n_checks++; if (wq.size() - start !== 4) $display("FAIL sw_write_count got %0d want 4", wq.size() - start); else n_pass++;
        if (wq.size() - start >= 4) begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (wq[start+k] !== {32'h100 + 32'(k), 8'(32'hDEADBEEF >> (8*k))})
                    $display("FAIL sw_byte%0d got %h want %h", k, wq[start+k], {32'h100 + 32'(k), 8'(32'hDEADBEEF >> (8*k))});
                else n_pass++;
            end
        end
        n_checks++; if (lat !== 5) $display("FAIL sw_latency got %0d want 5", lat); else n_pass++;
        n_checks++; if (pulses !== 1) $display("FAIL sw_pulses got %0d want 1", pulses); else n_pass++;
        run_ls(1'b0, 32'h102, 2'b00, 32'd0, 0, rd, lat, pulses);
        n_checks++; if (rd !== 32'h000000AD) $display("FAIL lb_data got %h want 000000ad", rd); else n_pass++;
        n_checks++; if (lat !== 3) $display("FAIL lb_latency got %0d want 3", lat); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [63:0] exp_blk, icb;
        logic [31:0] lsd;
        int ls_at, ic_at, icp, lsp;
        exp_blk = model_block(32'h40);
        icb = '0; lsd = '0; ls_at = -1; ic_at = -1; icp = 0; lsp = 0;
        @(negedge clk);
        ic_en = 1'b1; ic_addr = 32'h40;
        ls_en = 1'b1; ls_wr = 1'b0; ls_addr = 32'h100; ls_width = 2'b01;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ls_valid === 1'b1) begin
                lsp++; if (ls_at < 0) ls_at = c; lsd = ls_rdata; ls_en = 1'b0;
            end
            if (ic_valid === 1'b1) begin
                icp++; if (ic_at < 0) ic_at = c; icb = ic_blk; ic_en = 1'b0;
            end
        end
        n_checks++; if (ls_at !== 4) $display("FAIL sim_ls_cycle got %0d want 4", ls_at); else n_pass++;
        n_checks++; if (lsd !== 32'h0000BEEF) $display("FAIL sim_lh_data got %h want 0000beef", lsd); else n_pass++;
        n_checks++; if (ic_at !== 15) $display("FAIL sim_ic_cycle got %0d want 15", ic_at); else n_pass++;
        n_checks++; if (icp !== 1) $display("FAIL sim_ic_pulses got %0d want 1", icp); else n_pass++;
        n_checks++; if (lsp !== 1) $display("FAIL sim_ls_pulses got %0d want 1", lsp); else n_pass++;
        n_checks++; if (icb !== exp_blk) $display("FAIL sim_ic_blk got %h want %h", icb, exp_blk); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd, exp;
        logic [1:0] w;
        bit wr;
        int nb, lat, pulses, start;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            w = 2'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 4095));
            d = $urandom;
            nb = model_bytes(w);
            start = wq.size();
            run_ls(wr, a, w, d, 0, rd, lat, pulses);
            if (wr) begin
                model_store(a, nb, d);
                n_checks++; if (wq.size() - start !== nb) $display("FAIL rnd_st_count got %0d want %0d", wq.size() - start, nb); else n_pass++;
                if (wq.size() - start >= nb) begin
                    for (int k = 0; k < nb; k++) begin
                        n_checks++;
                        if (wq[start+k] !== {a + 32'(k), d[8*k +: 8]})
                            $display("FAIL rnd_st_byte got %h want %h", wq[start+k], {a + 32'(k), d[8*k +: 8]});
                        else n_pass++;
                    end
                end
                n_checks++; if (lat !== nb + 1) $display("FAIL rnd_st_latency got %0d want %0d", lat, nb + 1); else n_pass++;
            end else begin
                exp = model_load(a, nb);
                n_checks++; if (rd !== exp) $display("FAIL rnd_ld_data @%h w%0d got %h want %h", a, nb, rd, exp); else n_pass++;
                n_checks++; if (lat !== nb + 2) $display("FAIL rnd_ld_latency got %0d want %0d", lat, nb + 2); else n_pass++;
            end
        end
    endtask

    task automatic test_io_stall();
        logic [63:0] icb, exp_blk;
        logic [7:0] d;
        int start, got_v, ic_at, lat;
        d = 8'($urandom_range(0, 255));
        start = wq.size();
        io_buffer_full = 1'b1;
        @(negedge clk);
        ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h30000; ls_width = 2'b00; ls_wdata = {24'd0, d};
        got_v = 0;
        repeat (3) begin
            @(negedge clk);
            if (ls_valid === 1'b1) got_v++;
        end
        n_checks++; if (got_v !== 0) $display("FAIL io_early_valid got %0d want 0", got_v); else n_pass++;
        exp_blk = model_block(32'h48);
        ic_en = 1'b1; ic_addr = 32'h48; ic_at = -1; icb = '0;
        for (int c = 1; c <= 20 && ic_at < 0; c++) begin
            @(negedge clk);
            if (ls_valid === 1'b1) got_v++;
            if (ic_valid === 1'b1) begin
                ic_at = c; icb = ic_blk; ic_en = 1'b0;
            end
        end
        ic_en = 1'b0;
        n_checks++; if (ic_at !== 10) $display("FAIL io_ic_served_cycle got %0d want 10", ic_at); else n_pass++;
        n_checks++; if (icb !== exp_blk) $display("FAIL io_ic_blk got %h want %h", icb, exp_blk); else n_pass++;
        @(negedge clk);
        n_checks++; if (wq.size() - start !== 0) $display("FAIL io_blocked_writes got %0d want 0", wq.size() - start); else n_pass++;
        n_checks++; if (got_v !== 0) $display("FAIL io_blocked_valid got %0d want 0", got_v); else n_pass++;
        io_buffer_full = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (ls_valid === 1'b1) begin
                lat = c; ls_en = 1'b0;
            end
        end
        ls_en = 1'b0;
        model_store(32'h30000, 1, {24'd0, d});
        n_checks++; if (lat !== 2) $display("FAIL io_st_latency got %0d want 2", lat); else n_pass++;
        n_checks++; if (wq.size() - start !== 1) $display("FAIL io_write_count got %0d want 1", wq.size() - start); else n_pass++;
        if (wq.size() - start >= 1) begin
            n_checks++; if (wq[start] !== {32'h30000, d}) $display("FAIL io_write got %h want %h", wq[start], {32'h30000, d}); else n_pass++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rdy_stall();
        logic [63:0] blk;
        logic [31:0] d, rd;
        int lat, pulses, start, bad0;
        bad0 = bad_wr;
        run_ic(32'h80, 4, blk, lat, pulses);
        n_checks++; if (blk !== model_block(32'h80)) $display("FAIL stall_ic_blk got %h want %h", blk, model_block(32'h80)); else n_pass++;
        n_checks++; if (lat !== 16) $display("FAIL stall_ic_latency got %0d want 16", lat); else n_pass++;
        n_checks++; if (pulses !== 1) $display("FAIL stall_ic_pulses got %0d want 1", pulses); else n_pass++;
        d = $urandom;
        start = wq.size();
        run_ls(1'b1, 32'h200, 2'b10, d, 2, rd, lat, pulses);
        model_store(32'h200, 4, d);
        n_checks++; if (lat !== 7) $display("FAIL stall_sw_latency got %0d want 7", lat); else n_pass++;
        n_checks++; if (wq.size() - start !== 4) $display("FAIL stall_sw_count got %0d want 4", wq.size() - start); else n_pass++;
        if (wq.size() - start >= 4) begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (wq[start+k] !== {32'h200 + 32'(k), d[8*k +: 8]})
                    $display("FAIL stall_sw_byte%0d got %h want %h", k, wq[start+k], {32'h200 + 32'(k), d[8*k +: 8]});
                else n_pass++;
            end
        end
        n_checks++; if (bad_wr - bad0 !== 0) $display("FAIL stall_wr_while_low got %0d want 0", bad_wr - bad0); else n_pass++;
        run_ls(1'b0, 32'h200, 2'b10, 32'd0, 0, rd, lat, pulses);
        n_checks++; if (rd !== model_load(32'h200, 4)) $display("FAIL stall_readback got %h want %h", rd, model_load(32'h200, 4)); else n_pass++;
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] d, rd;
        int lat, pulses, start, got_v;
        d = $urandom;
        @(negedge clk);
        ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h300; ls_width = 2'b10; ls_wdata = d;
        repeat (2) @(negedge clk);
        rst = 1'b1; ls_en = 1'b0;
        #1;
        n_checks++; if (mem_wr !== 1'b0) $display("FAIL mid_rst_mem_wr got %b want 0", mem_wr); else n_pass++;
        n_checks++; if (mem_a !== 32'd0) $display("FAIL mid_rst_mem_a got %h want 0", mem_a); else n_pass++;
        n_checks++; if (mem_dout !== 8'd0) $display("FAIL mid_rst_mem_dout got %h want 0", mem_dout); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        got_v = 0;
        repeat (4) begin
            @(negedge clk);
            if (ls_valid === 1'b1) got_v++;
        end
        n_checks++; if (got_v !== 0) $display("FAIL mid_rst_valid got %0d want 0", got_v); else n_pass++;
        start = wq.size();
        run_ls(1'b1, 32'h300, 2'b10, d, 0, rd, lat, pulses);
        model_store(32'h300, 4, d);
        n_checks++; if (lat !== 5) $display("FAIL reissue_latency got %0d want 5", lat); else n_pass++;
        n_checks++; if (pulses !== 1) $display("FAIL reissue_pulses got %0d want 1", pulses); else n_pass++;
        n_checks++; if (wq.size() - start !== 4) $display("FAIL reissue_count got %0d want 4", wq.size() - start); else n_pass++;
        run_ls(1'b0, 32'h300, 2'b10, 32'd0, 0, rd, lat, pulses);
        n_checks++; if (rd !== model_load(32'h300, 4)) $display("FAIL reissue_readback got %h want %h", rd, model_load(32'h300, 4)); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
        repeat (3) @(negedge clk);
        test_reset();
        test_icache();
        test_store_load();
        test_simultaneous();
        test_random();
        test_io_stall();
        test_rdy_stall();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
